// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The DMEM_BOUNDS_CHECK_EN option is applied in dmem_responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;

    // Expand byte-lane enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised storage with per-byte-lane write enables.
// An active reset re-initialises every word within a single cycle and overrides any write.
module dmem_byte_ram
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] INIT_VALUE  = 32'h0000_0000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [3:0]                     wr_lane,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
    input  logic [31:0]                    wr_data,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
    output logic [31:0]                    rd_data
);

    logic [31:0] mem_r [DEPTH_WORDS];

    // Storage update: reset fill has priority over a coincident lane write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem_r[i] <= INIT_VALUE;
            end
        end else if (wr_lane != 4'b0000) begin
            mem_r[wr_idx] <= (mem_r[wr_idx] & ~lane_mask(wr_lane)) |
                             (wr_data & lane_mask(wr_lane));
        end
    end

    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with configurable access latency.
// Define DMEM_BOUNDS_CHECK_EN to flag out-of-range and misaligned word accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] INIT_VALUE  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    dmem_state_t state_r;
    logic [3:0]  cnt_r;
    dmem_req_t   req_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;

    dmem_req_t   in_req_s;
    dmem_req_t   cur_req_s;
    logic        accept_s;
    logic        commit_s;
    logic        err_s;
    logic [31:0] rsp_data_s;
    logic [3:0]  wr_lane_s;
    logic [AW-1:0] idx_s;
    logic [31:0] ram_rdata_s;

    // Select the request being committed: a fresh one only matters for zero latency.
    always_comb begin
        in_req_s.we    = req_we;
        in_req_s.addr  = req_addr;
        in_req_s.wdata = req_wdata;
        in_req_s.be    = req_be;
        accept_s       = req_valid & req_ready_r;
        if (state_r == IDLE) begin
            cur_req_s = in_req_s;
        end else begin
            cur_req_s = req_r;
        end
        case (state_r)
            IDLE:    commit_s = accept_s && (LATENCY == 0);
            WAIT:    commit_s = (cnt_r == 4'd0);
            default: commit_s = 1'b0;
        endcase
    end

    assign idx_s = cur_req_s.addr[AW+1:2];

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

    // Fault on addresses past the array or word stores off a word boundary.
    always_comb begin
        if ((cur_req_s.addr >= ADDR_LIMIT) ||
            ((cur_req_s.be == 4'b1111) && (cur_req_s.addr[1:0] != 2'b00))) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end
`else
    logic addr_unused_s;
    assign addr_unused_s = ^{cur_req_s.addr[31:AW+2], cur_req_s.addr[1:0]};
    assign err_s = 1'b0;
`endif

    // Response payload and lane writes produced at the commit point.
    always_comb begin
        if (cur_req_s.we) begin
            rsp_data_s = 32'h0000_0000;
        end else if (err_s) begin
            rsp_data_s = DMEM_ERR_DATA;
        end else begin
            rsp_data_s = ram_rdata_s;
        end
        if (commit_s && cur_req_s.we && !err_s) begin
            wr_lane_s = cur_req_s.be;
        end else begin
            wr_lane_s = 4'b0000;
        end
    end

    dmem_byte_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .INIT_VALUE  (INIT_VALUE)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_lane (wr_lane_s),
        .wr_idx  (idx_s),
        .wr_data (cur_req_s.wdata),
        .rd_idx  (idx_s),
        .rd_data (ram_rdata_s)
    );

    // Control FSM, latency counter and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            req_r       <= '0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        req_r       <= in_req_s;
                        req_ready_r <= 1'b0;
                        if (LATENCY == 0) begin
                            state_r     <= RESP;
                            rsp_valid_r <= 1'b1;
                            rsp_rdata_r <= rsp_data_s;
                            rsp_err_r   <= err_s;
                        end else begin
                            state_r <= WAIT;
                            cnt_r   <= CNT_INIT;
                        end
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt_r == 4'd0) begin
                        state_r     <= RESP;
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= rsp_data_s;
                        rsp_err_r   <= err_s;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_r     <= IDLE;
                        req_ready_r <= 1'b1;
                        rsp_valid_r <= 1'b0;
                        rsp_rdata_r <= 32'h0000_0000;
                        rsp_err_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= 4'd0;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    rsp_rdata_r <= 32'h0000_0000;
                    rsp_err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the memory stage of the DeepPipeline ARM core.
- Accepts one load/store request at a time over a valid/ready request channel.
- Models configurable access latency, then returns read data and status over a valid/ready response channel.
- The pipeline stalls its memory stage on `req_ready`/`rsp_valid`.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words stored; must be a power of two ≥ 4.
- LATENCY, 2, cycles from request acceptance to `rsp_valid`; legal range 0–15.
- INIT_VALUE, 32'h0000_0000, value written to every word on reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, little-endian lanes.
- req_be  input  4  byte-lane enables (STR = 4'b1111, STRB = one-hot lane).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  pipeline accepts the response.
- rsp_rdata  output  32  load data (full word, unmasked); 0 for stores.
- rsp_err  output  1  access fault (see optional feature); 0 otherwise.

Behaviour:
- Reset (`rst_n` = 0 at a rising edge):
  - Outputs: `req_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_err` = 0.
  - FSM goes to IDLE and the latency counter clears.
  - Memory is re-initialised to INIT_VALUE. Implement as a per-word loop, so reset takes effect in one cycle.
- Reset mid-operation: aborts any in-flight access. A pending store whose commit cycle coincides with reset is not performed.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: `req_ready` = 1. On `req_valid & req_ready`, latch we/addr/wdata/be into the request register.
    - LATENCY = 0: go directly to RESP.
    - Otherwise: load counter with LATENCY-1 and go to WAIT.
  - WAIT: `req_ready` = 0. Counter decrements each cycle. When it reaches 0, go to RESP.
  - Access commit happens on the transition into RESP:
    - Store: for each lane i with `be[i]` = 1, write the byte. Lanes with `be[i]` = 0 are unchanged.
    - Load: capture word `mem[addr[log2(DEPTH_WORDS)+1:2]]` into `rsp_rdata`.
  - RESP: `rsp_valid` = 1. `rsp_rdata`/`rsp_err` stay stable until `rsp_valid & rsp_ready`, then go to IDLE. `req_ready` = 0 in RESP.
- Latency: a request accepted in cycle N gives `rsp_valid` in cycle N+LATENCY+1 (registered). Minimum round trip with immediate `rsp_ready` is LATENCY+2 cycles.
- Only one outstanding request. No request is accepted while in WAIT or RESP.
- Addressing:
  - `addr[1:0]` is ignored for word selection.
  - Upper bits beyond the index wrap (aliasing) when bounds checking is compiled out.
- Store with `be` = 4'b0000: legal no-op, still produces a response.
- `rsp_ready` held high before `rsp_valid`: response completes in its first RESP cycle.
- `req_valid` dropped while `req_ready` = 0: no effect.
- Read-after-write: a load issued after a store's response reads the new data.

Optional Feature:
- Macro: DMEM_BOUNDS_CHECK_EN.
- Defined:
  - A request with `req_addr >= 4*DEPTH_WORDS`, or a word store (`be` = 4'b1111) with `addr[1:0]` ≠ 0, sets `rsp_err` = 1.
  - For an erroring store, no memory write occurs.
  - For an erroring load, `rsp_rdata` = 32'hDEAD_BEEF.
  - Latency and handshake are unchanged.
- Undefined: the address wraps modulo the depth, misalignment is ignored, and `rsp_err` is tied to 0.

Decomposition:
- Package `dmem_pkg`:
  - typedef `dmem_state_t` enum {IDLE, WAIT, RESP}.
  - typedef `dmem_req_t` struct {we, addr, wdata, be}.
  - constant `DMEM_ERR_DATA` = 32'hDEAD_BEEF.
- One sub-module: `dmem_byte_ram`, the storage array with per-lane write enables and synchronous reset init.
- `dmem_responder` keeps the FSM, counter and handshake logic.

Test Plan:
- Reset then word store: LATENCY=2, store addr 0x10 data 0x11223344 be 4'hF → `rsp_valid` 3 cycles after accept, `rsp_rdata` = 0. A following load of 0x10 returns 0x11223344.
- Byte store: STRB to addr 0x11, data 0x0000AB00, be 4'b0010, over word 0x11223344 → load of 0x10 returns 0x1122AB44.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles in RESP → `rsp_valid`/`rsp_rdata` stable and `req_ready` = 0 throughout. Release → IDLE the next cycle.
- LATENCY=0 build: back-to-back loads with `rsp_ready` = 1 → one response every 2 cycles with correct data.
- Reset mid-WAIT: accept a store of 0xCAFEF00D to 0x20, assert `rst_n` = 0 in WAIT → all outputs 0. A load of 0x20 afterwards returns INIT_VALUE.
- DMEM_BOUNDS_CHECK_EN: load 0x400 with DEPTH_WORDS=256 → `rsp_err` = 1, `rsp_rdata` = 0xDEADBEEF. Word store to 0x22 → `rsp_err` = 1, memory unchanged. Without the macro, a load of 0x400 returns word 0 and `rsp_err` = 0.
